controller_data_ram_arbiter: RTL and testbench

//  Two-requester arbiter that shares a single port (s2) of the controller data RAM
//  (2048 x 32, byte-enabled, one-cycle read latency) between requesters A and B.

---
 rtl/controller_data_ram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_controller_data_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_data_ram_arbiter.sv
// Purpose: shares port 2 of the 2048x32 controller data RAM between two Avalon-MM requesters (A, B) using round-robin arbitration with an optional timed lock.
// Latency: a grant is combinational, so waitrequest drops in the request cycle; readdatavalid follows one cycle after a read is accepted.
// Backpressure: the losing or locked-out requester sees waitrequest=1 and must hold its request; full throughput, one transfer per cycle.
module controller_data_ram_arbiter #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   // requester A
   input  logic [ADDR_W-1:0]     a_address,
   input  logic [DATA_W/8-1:0]   a_byteenable,
   input  logic                  a_read,
   input  logic                  a_write,
   input  logic [DATA_W-1:0]     a_writedata,
   input  logic                  a_lock,
   output logic                  a_waitrequest,
   output logic [DATA_W-1:0]     a_readdata,
   output logic                  a_readdatavalid,
   // requester B
   input  logic [ADDR_W-1:0]     b_address,
   input  logic [DATA_W/8-1:0]   b_byteenable,
   input  logic                  b_read,
   input  logic                  b_write,
   input  logic [DATA_W-1:0]     b_writedata,
   input  logic                  b_lock,
   output logic                  b_waitrequest,
   output logic [DATA_W-1:0]     b_readdata,
   output logic                  b_readdatavalid,
   // RAM port 2
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic [DATA_W-1:0]     ram_writedata,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic                  ram_clken,
   input  logic [DATA_W-1:0]     ram_readdata,
   // status
   output logic                  lock_timeout
);

   // The counter must reach LOCK_MAX-1; a zero LOCK_MAX disables the timeout
   // but a one-bit counter is kept so the declarations stay legal.
   localparam int               CNT_W      = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
   localparam bit               TIMEOUT_EN = (LOCK_MAX > 0);
   localparam logic [CNT_W-1:0] CNT_LAST   = (LOCK_MAX > 0) ? CNT_W'(LOCK_MAX - 1) : '0;

   // Requester identifiers used for last_grant / rd_owner / mux select
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_last_grant;
   logic [CNT_W-1:0]  r_lock_cnt;
   logic              r_rd_pend;
   logic              r_rd_owner;

   logic              w_req_a;
   logic              w_req_b;
   logic              w_grant_a;
   logic              w_grant_b;
   logic              w_accept;
   logic              w_sel;
   logic              w_sel_read;
   logic              w_sel_write;
   logic              w_sel_lock;
   logic              w_acc_rd;
   logic              w_acc_wr;
   logic              w_timeout;

   assign w_req_a = a_read | a_write;
   assign w_req_b = b_read | b_write;

   // Grant selection: round-robin when unlocked, owner-only when locked, nothing during reset
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (reset_n) begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_a && w_req_b) begin
                  // Tie goes to whoever was not served last
                  if (r_last_grant == SEL_B) begin
                     w_grant_a = 1'b1;
                  end else begin
                     w_grant_b = 1'b1;
                  end
               end else begin
                  w_grant_a = w_req_a;
                  w_grant_b = w_req_b;
               end
            end
            ST_OWN_A: w_grant_a = w_req_a;
            ST_OWN_B: w_grant_b = w_req_b;
            default: begin
               w_grant_a = 1'b0;
               w_grant_b = 1'b0;
            end
         endcase
      end
   end

   // Winner-side view of the request; read+write together counts as a write only
   always_comb begin
      w_accept    = w_grant_a | w_grant_b;
      w_sel       = w_grant_b ? SEL_B : SEL_A;
      w_sel_read  = (w_sel == SEL_B) ? b_read  : a_read;
      w_sel_write = (w_sel == SEL_B) ? b_write : a_write;
      w_sel_lock  = (w_sel == SEL_B) ? b_lock  : a_lock;
      w_acc_wr    = w_accept & w_sel_write;
      w_acc_rd    = w_accept & w_sel_read & ~w_sel_write;
      // Force-release fires in the last allowed owned cycle; that cycle's transfer still goes through
      w_timeout   = TIMEOUT_EN && reset_n && (r_state != ST_IDLE) && (r_lock_cnt == CNT_LAST);
   end

   // Lock FSM state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Lock FSM next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_sel_lock) begin
               w_next_state = (w_sel == SEL_B) ? ST_OWN_B : ST_OWN_A;
            end
         end
         ST_OWN_A: begin
            // The owner always wins while requesting, so dropping lock releases
            // whether or not a transfer happens this cycle.
            if (w_timeout || !a_lock) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_OWN_B: begin
            if (w_timeout || !b_lock) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Lock FSM / datapath outputs
   always_comb begin
      a_waitrequest   = ~w_grant_a;
      b_waitrequest   = ~w_grant_b;
      ram_address     = (w_sel == SEL_B) ? b_address    : a_address;
      ram_byteenable  = (w_sel == SEL_B) ? b_byteenable : a_byteenable;
      ram_writedata   = (w_sel == SEL_B) ? b_writedata  : a_writedata;
      ram_chipselect  = w_accept;
      ram_write       = w_acc_wr;
      ram_clken       = 1'b1;
      lock_timeout    = w_timeout;
      // Gated by reset_n so a reset right after an accept swallows the response
      a_readdatavalid = reset_n & r_rd_pend & (r_rd_owner == SEL_A);
      b_readdatavalid = reset_n & r_rd_pend & (r_rd_owner == SEL_B);
      a_readdata      = ram_readdata;
      b_readdata      = ram_readdata;
   end

   // Round-robin history; a force-release charges the turn to the old owner so the other side wins the next tie
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_last_grant <= SEL_B;
      end else if (w_timeout) begin
         r_last_grant <= (r_state == ST_OWN_B) ? SEL_B : SEL_A;
      end else if (w_accept) begin
         r_last_grant <= w_sel;
      end
   end

   // Lock-hold counter: held at zero outside ownership so it starts from zero on entry
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_lock_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         r_lock_cnt <= '0;
      end else if (TIMEOUT_EN) begin
         r_lock_cnt <= r_lock_cnt + CNT_W'(1);
      end
   end

   // Read response tracking: one pending read at most, matching the RAM's one-cycle latency
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_pend  <= 1'b0;
         r_rd_owner <= SEL_A;
      end else begin
         r_rd_pend <= w_acc_rd;
         if (w_acc_rd) begin
            r_rd_owner <= w_sel;
         end
      end
   end

endmodule

// File: tb/tb_controller_data_ram_arbiter.sv
module tb_controller_data_ram_arbiter;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int LM = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] a_address, b_address;
   logic [BW-1:0] a_byteenable, b_byteenable;
   logic          a_read, a_write, a_lock, b_read, b_write, b_lock;
   logic [DW-1:0] a_writedata, b_writedata;
   logic          a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
   logic [DW-1:0] a_readdata, b_readdata;
   logic [AW-1:0] ram_address;
   logic [BW-1:0] ram_byteenable;
   logic [DW-1:0] ram_writedata, ram_readdata;
   logic          ram_chipselect, ram_write, ram_clken, lock_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   controller_data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
      .a_writedata(a_writedata), .a_lock(a_lock), .a_waitrequest(a_waitrequest),
      .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
      .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
      .b_writedata(b_writedata), .b_lock(b_lock), .b_waitrequest(b_waitrequest),
      .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_clken(ram_clken),
      .ram_readdata(ram_readdata), .lock_timeout(lock_timeout)
   );

   // RAM port-2 model: byte-enabled write, registered read; contents are A500_0000|addr after reset
   logic [DW-1:0] mem [0:2047];
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int k = 0; k < BW; k++)
               if (ram_byteenable[k]) mem[ram_address][8*k +: 8] <= ram_writedata[8*k +: 8];
         end
         ram_readdata <= mem[ram_address];
      end
   end

   typedef struct {
      string         nm;
      logic          rst_n;
      logic          a_rd, a_wr;
      logic [AW-1:0] a_ad;
      logic [BW-1:0] a_be;
      logic [DW-1:0] a_wd;
      logic          b_rd;
      logic [AW-1:0] b_ad;
      logic          e_aw, e_bw, e_av, e_bv, e_cs, e_we;
      logic [AW-1:0] e_ad;
      logic [DW-1:0] e_d;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic rst_n,
                               input logic a_rd, input logic a_wr, input logic [AW-1:0] a_ad,
                               input logic [BW-1:0] a_be, input logic [DW-1:0] a_wd,
                               input logic b_rd, input logic [AW-1:0] b_ad,
                               input logic e_aw, input logic e_bw, input logic e_av, input logic e_bv,
                               input logic e_cs, input logic e_we, input logic [AW-1:0] e_ad,
                               input logic [DW-1:0] e_d);
      vec_t v;
      v.nm = nm; v.rst_n = rst_n;
      v.a_rd = a_rd; v.a_wr = a_wr; v.a_ad = a_ad; v.a_be = a_be; v.a_wd = a_wd;
      v.b_rd = b_rd; v.b_ad = b_ad;
      v.e_aw = e_aw; v.e_bw = e_bw; v.e_av = e_av; v.e_bv = e_bv;
      v.e_cs = e_cs; v.e_we = e_we; v.e_ad = e_ad; v.e_d = e_d;
      return v;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rn,
                        input logic ard, input logic awr, input logic alk, input logic [AW-1:0] aad,
                        input logic [BW-1:0] abe, input logic [DW-1:0] awd,
                        input logic brd, input logic blk, input logic [AW-1:0] bad);
      reset_n = rn;
      a_read = ard; a_write = awr; a_lock = alk; a_address = aad; a_byteenable = abe; a_writedata = awd;
      b_read = brd; b_write = 1'b0; b_lock = blk; b_address = bad; b_byteenable = 4'hF; b_writedata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      vec_t v;
      //          name         rst rd wr a_ad    be    wd            brd b_ad     aw bw av bv cs we e_ad    e_d
      vecs.push_back(mk("rst",      0, 1, 0, 11'h010, 4'hF, 32'h0,        1, 11'h010, 1, 1, 0, 0, 0, 0, 11'h000, 32'h0));
      vecs.push_back(mk("idle",     1, 0, 0, 11'h000, 4'hF, 32'h0,        0, 11'h000, 1, 1, 0, 0, 0, 0, 11'h000, 32'h0));
      vecs.push_back(mk("a_rd",     1, 1, 0, 11'h010, 4'hF, 32'h0,        0, 11'h000, 0, 1, 0, 0, 1, 0, 11'h010, 32'h0));
      vecs.push_back(mk("a_rdv",    1, 0, 0, 11'h000, 4'hF, 32'h0,        0, 11'h000, 1, 1, 1, 0, 0, 0, 11'h000, 32'hA500_0010));
      vecs.push_back(mk("idle2",    1, 0, 0, 11'h000, 4'hF, 32'h0,        0, 11'h000, 1, 1, 0, 0, 0, 0, 11'h000, 32'h0));
      vecs.push_back(mk("rst2",     0, 0, 0, 11'h000, 4'hF, 32'h0,        0, 11'h000, 1, 1, 0, 0, 0, 0, 11'h000, 32'h0));
      vecs.push_back(mk("alt0",     1, 1, 0, 11'h100, 4'hF, 32'h0,        1, 11'h200, 0, 1, 0, 0, 1, 0, 11'h100, 32'h0));
      vecs.push_back(mk("alt1",     1, 1, 0, 11'h101, 4'hF, 32'h0,        1, 11'h200, 1, 0, 1, 0, 1, 0, 11'h200, 32'hA500_0100));
      vecs.push_back(mk("alt2",     1, 1, 0, 11'h101, 4'hF, 32'h0,        1, 11'h201, 0, 1, 0, 1, 1, 0, 11'h101, 32'hA500_0200));
      vecs.push_back(mk("alt3",     1, 1, 0, 11'h102, 4'hF, 32'h0,        1, 11'h201, 1, 0, 1, 0, 1, 0, 11'h201, 32'hA500_0101));
      vecs.push_back(mk("alt4",     1, 1, 0, 11'h102, 4'hF, 32'h0,        1, 11'h202, 0, 1, 0, 1, 1, 0, 11'h102, 32'hA500_0201));
      vecs.push_back(mk("alt5",     1, 1, 0, 11'h103, 4'hF, 32'h0,        1, 11'h202, 1, 0, 1, 0, 1, 0, 11'h202, 32'hA500_0102));
      vecs.push_back(mk("alt6",     1, 1, 0, 11'h103, 4'hF, 32'h0,        1, 11'h203, 0, 1, 0, 1, 1, 0, 11'h103, 32'hA500_0202));
      vecs.push_back(mk("alt7",     1, 1, 0, 11'h104, 4'hF, 32'h0,        1, 11'h203, 1, 0, 1, 0, 1, 0, 11'h203, 32'hA500_0103));
      vecs.push_back(mk("alt_end",  1, 0, 0, 11'h000, 4'hF, 32'h0,        0, 11'h000, 1, 1, 0, 1, 0, 0, 11'h000, 32'hA500_0203));
      vecs.push_back(mk("a_wr_7ff", 1, 0, 1, 11'h7FF, 4'h3, 32'hDEADBEEF, 0, 11'h000, 0, 1, 0, 0, 1, 1, 11'h7FF, 32'h0));
      vecs.push_back(mk("b_rd_7ff", 1, 0, 0, 11'h000, 4'hF, 32'h0,        1, 11'h7FF, 1, 0, 0, 0, 1, 0, 11'h7FF, 32'h0));
      vecs.push_back(mk("b_rdv_7ff",1, 0, 0, 11'h000, 4'hF, 32'h0,        0, 11'h000, 1, 1, 0, 1, 0, 0, 11'h000, 32'hA500_BEEF));
      vecs.push_back(mk("a_rdwr",   1, 1, 1, 11'h030, 4'hF, 32'h12345678, 0, 11'h000, 0, 1, 0, 0, 1, 1, 11'h030, 32'h0));
      vecs.push_back(mk("no_rdv",   1, 0, 0, 11'h000, 4'hF, 32'h0,        0, 11'h000, 1, 1, 0, 0, 0, 0, 11'h000, 32'h0));
      vecs.push_back(mk("b_rd_030", 1, 0, 0, 11'h000, 4'hF, 32'h0,        1, 11'h030, 1, 0, 0, 0, 1, 0, 11'h030, 32'h0));
      vecs.push_back(mk("b_rdv_030",1, 0, 0, 11'h000, 4'hF, 32'h0,        0, 11'h000, 1, 1, 0, 1, 0, 0, 11'h000, 32'h12345678));

      // initial reset, two edges
      drive(0, 0, 0, 0, '0, 4'hF, '0, 0, 0, '0);
      next_cycle();
      next_cycle();

      foreach (vecs[i]) begin
         v = vecs[i];
         drive(v.rst_n, v.a_rd, v.a_wr, 1'b0, v.a_ad, v.a_be, v.a_wd, v.b_rd, 1'b0, v.b_ad);
         @(negedge clk);
         chk1({v.nm, " a_waitrequest"}, a_waitrequest, v.e_aw);
         chk1({v.nm, " b_waitrequest"}, b_waitrequest, v.e_bw);
         chk1({v.nm, " a_readdatavalid"}, a_readdatavalid, v.e_av);
         chk1({v.nm, " b_readdatavalid"}, b_readdatavalid, v.e_bv);
         chk1({v.nm, " ram_chipselect"}, ram_chipselect, v.e_cs);
         chk1({v.nm, " ram_write"}, ram_write, v.e_we);
         chk1({v.nm, " lock_timeout"}, lock_timeout, 1'b0);
         if (v.e_cs) chk32({v.nm, " ram_address"}, 32'(ram_address), 32'(v.e_ad));
         if (v.e_av) chk32({v.nm, " a_readdata"}, a_readdata, v.e_d);
         if (v.e_bv) chk32({v.nm, " b_readdata"}, b_readdata, v.e_d);
         next_cycle();
      end

      // Lock held across read, read, unlocked write; B requests throughout (IDLE, last_grant=B)
      drive(1, 1, 0, 1, 11'h020, 4'hF, '0, 1, 0, 11'h300);
      @(negedge clk);
      chk1("lk1 a_waitrequest", a_waitrequest, 1'b0);
      chk1("lk1 b_waitrequest", b_waitrequest, 1'b1);
      next_cycle();
      drive(1, 1, 0, 1, 11'h021, 4'hF, '0, 1, 0, 11'h300);
      @(negedge clk);
      chk1("lk2 a_waitrequest", a_waitrequest, 1'b0);
      chk1("lk2 b_waitrequest", b_waitrequest, 1'b1);
      chk1("lk2 a_readdatavalid", a_readdatavalid, 1'b1);
      chk32("lk2 a_readdata", a_readdata, 32'hA500_0020);
      next_cycle();
      drive(1, 0, 1, 0, 11'h020, 4'hF, 32'hCAFEF00D, 1, 0, 11'h300);
      @(negedge clk);
      chk1("lk3 a_waitrequest", a_waitrequest, 1'b0);
      chk1("lk3 b_waitrequest", b_waitrequest, 1'b1);
      chk1("lk3 ram_write", ram_write, 1'b1);
      chk32("lk3 a_readdata", a_readdata, 32'hA500_0021);
      next_cycle();
      drive(1, 0, 0, 0, '0, 4'hF, '0, 1, 0, 11'h300);
      @(negedge clk);
      chk1("lk4 b_waitrequest", b_waitrequest, 1'b0);
      chk1("lk4 a_readdatavalid", a_readdatavalid, 1'b0);
      next_cycle();
      drive(1, 0, 0, 0, '0, 4'hF, '0, 0, 0, '0);
      @(negedge clk);
      chk1("lk5 b_readdatavalid", b_readdatavalid, 1'b1);
      chk32("lk5 b_readdata", b_readdata, 32'hA500_0300);
      next_cycle();

      // Lock timeout: A keeps lock and requests, B pending; entry cycle then 16 owned cycles
      drive(1, 1, 0, 1, 11'h040, 4'hF, '0, 1, 0, 11'h301);
      @(negedge clk);
      chk1("to0 a_waitrequest", a_waitrequest, 1'b0);
      chk1("to0 b_waitrequest", b_waitrequest, 1'b1);
      next_cycle();
      for (int k = 1; k <= LM; k++) begin
         @(negedge clk);
         chk1($sformatf("to%0d a_waitrequest", k), a_waitrequest, 1'b0);
         chk1($sformatf("to%0d b_waitrequest", k), b_waitrequest, 1'b1);
         chk1($sformatf("to%0d lock_timeout", k), lock_timeout, (k == LM));
         next_cycle();
      end
      @(negedge clk);
      chk1("to_after b_waitrequest", b_waitrequest, 1'b0);
      chk1("to_after a_waitrequest", a_waitrequest, 1'b1);
      chk1("to_after lock_timeout", lock_timeout, 1'b0);
      next_cycle();
      drive(1, 0, 0, 0, '0, 4'hF, '0, 0, 0, '0);
      @(negedge clk);
      chk1("to_rdv b_readdatavalid", b_readdatavalid, 1'b1);
      chk32("to_rdv b_readdata", b_readdata, 32'hA500_0301);
      next_cycle();

      // Reset the cycle after an A read accept: the response must be discarded
      drive(1, 1, 0, 0, 11'h010, 4'hF, '0, 0, 0, '0);
      @(negedge clk);
      chk1("rr0 a_waitrequest", a_waitrequest, 1'b0);
      next_cycle();
      drive(0, 1, 0, 0, 11'h010, 4'hF, '0, 1, 0, 11'h010);
      @(negedge clk);
      chk1("rr1 a_readdatavalid", a_readdatavalid, 1'b0);
      chk1("rr1 b_readdatavalid", b_readdatavalid, 1'b0);
      chk1("rr1 a_waitrequest", a_waitrequest, 1'b1);
      chk1("rr1 b_waitrequest", b_waitrequest, 1'b1);
      chk1("rr1 ram_chipselect", ram_chipselect, 1'b0);
      chk1("rr1 ram_write", ram_write, 1'b0);
      chk1("rr1 lock_timeout", lock_timeout, 1'b0);
      next_cycle();
      drive(1, 0, 0, 0, '0, 4'hF, '0, 0, 0, '0);
      @(negedge clk);
      chk1("rr2 a_readdatavalid", a_readdatavalid, 1'b0);
      chk1("rr2 b_readdatavalid", b_readdatavalid, 1'b0);
      chk1("rr2 ram_chipselect", ram_chipselect, 1'b0);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
